// File: rtl/heq_phase_sequencer.sv
// Phase controller for the histogram equalizer: sequences HIST -> gap -> CDF -> gap -> MAP -> FIN and arbitrates scratchpad m2.
// Latency: stage starts and m2_owner are registered from next-state, so a phase's start is high in its first cycle.
// Backpressure: none; go is sampled only in IDLE (dropped otherwise). Optional feature macro: HEQ_PINGPONG_EN.
module heq_phase_sequencer #(
  parameter int unsigned        GAP_CYCLES     = 4,
  parameter int unsigned        CNT_W          = 24,
  parameter logic [CNT_W-1:0]   TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        go,
  input  logic        frame_base,
  input  logic        hist_done,
  input  logic        cdf_done,
  input  logic        cdf_valid,
  input  logic [19:0] cdf_min_in,
  input  logic        map_done,
  output logic        hist_start,
  output logic        cdf_start,
  output logic        map_start,
  output logic [1:0]  m2_owner,
  output logic        input_base_offset,
  output logic [19:0] cdf_min,
  output logic        busy,
  output logic        frame_done,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIST,
    ST_GAP1,
    ST_CDF,
    ST_GAP2,
    ST_MAP,
    ST_FIN
  } state_t;

  // Last counter value of a phase before the watchdog fires / the gap ends.
  localparam logic [CNT_W-1:0] TO_LAST  = TIMEOUT_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  logic             go_accept;

`ifdef HEQ_PINGPONG_EN
  // Set once the first frame has been accepted; afterwards frame_base is ignored.
  logic             pp_armed;
`endif

  assign go_accept = (state == ST_IDLE) && go;

  // Next-state decode: done levels only matter inside their own phase; done beats watchdog.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_HIST;
      end
      ST_HIST: begin
        if (hist_done) begin
          state_nxt = ST_GAP1;
        end else if (cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_GAP1: begin
        if (cnt == GAP_LAST) state_nxt = ST_CDF;
      end
      ST_CDF: begin
        if (cdf_done) begin
          state_nxt = ST_GAP2;
        end else if (cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_GAP2: begin
        if (cnt == GAP_LAST) state_nxt = ST_MAP;
      end
      ST_MAP: begin
        if (map_done) begin
          state_nxt = ST_FIN;
        end else if (cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, phase counter and all registered outputs; reset drops every start asynchronously.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      hist_start        <= 1'b0;
      cdf_start         <= 1'b0;
      map_start         <= 1'b0;
      m2_owner          <= 2'd0;
      input_base_offset <= 1'b0;
      cdf_min           <= 20'd0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      err_timeout       <= 1'b0;
`ifdef HEQ_PINGPONG_EN
      pp_armed          <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      // Counter restarts on every state entry and saturates rather than wrapping.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if ((state != ST_IDLE) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end

      // Outputs reflect the state being entered, so they move on the same edge as the state.
      hist_start <= (state_nxt == ST_HIST);
      cdf_start  <= (state_nxt == ST_CDF);
      map_start  <= (state_nxt == ST_MAP);
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state_nxt == ST_FIN);
      case (state_nxt)
        ST_HIST: m2_owner <= 2'd1;
        ST_CDF:  m2_owner <= 2'd2;
        ST_MAP:  m2_owner <= 2'd3;
        default: m2_owner <= 2'd0;
      endcase

      // A new frame clears the previous frame's error and CDF minimum.
      if (go_accept) begin
        err_timeout <= 1'b0;
        cdf_min     <= 20'd0;
      end else if (timeout_hit) begin
        err_timeout <= 1'b1;
      end

      // Last cdf_valid of the CDF phase wins.
      if ((state == ST_CDF) && cdf_valid) begin
        cdf_min <= cdf_min_in;
      end

`ifdef HEQ_PINGPONG_EN
      // First frame takes frame_base; each completed frame flips the bank. Aborts do not flip.
      if (go_accept) begin
        if (!pp_armed) input_base_offset <= frame_base;
        pp_armed <= 1'b1;
      end
      if (state_nxt == ST_FIN) begin
        input_base_offset <= ~input_base_offset;
      end
`else
      if (go_accept) begin
        input_base_offset <= frame_base;
      end
`endif
    end
  end

endmodule

// File: tb/tb_heq_phase_sequencer.sv
// Self-checking bench for heq_phase_sequencer: table of {inputs, repeat, expected outputs} rows
// applied through a scoreboard queue, plus hand-written timeout, stale-done, async-reset and
// back-to-back frame sequences.
module tb_heq_phase_sequencer;

  localparam logic [23:0] TO = 24'd100;
`ifdef HEQ_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_HIST = 1;
  localparam int P_GAP  = 2;
  localparam int P_CDF  = 3;
  localparam int P_MAP  = 4;
  localparam int P_FIN  = 5;

  typedef struct packed {
    logic        go;
    logic        base;
    logic        hd;
    logic        cd;
    logic        cv;
    logic [19:0] cm;
    logic        md;
  } in_t;

  typedef struct packed {
    logic        hs;
    logic        cs;
    logic        ms;
    logic [1:0]  own;
    logic        busy;
    logic        fd;
    logic        err;
    logic        ibo;
    logic [19:0] cmin;
  } out_t;

  typedef struct {
    in_t  i;
    int   n;
    out_t e;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        go;
  logic        frame_base;
  logic        hist_done;
  logic        cdf_done;
  logic        cdf_valid;
  logic [19:0] cdf_min_in;
  logic        map_done;
  logic        hist_start;
  logic        cdf_start;
  logic        map_start;
  logic [1:0]  m2_owner;
  logic        input_base_offset;
  logic [19:0] cdf_min;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;

  heq_phase_sequencer #(
    .GAP_CYCLES(4),
    .CNT_W(24),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .go(go),
    .frame_base(frame_base),
    .hist_done(hist_done),
    .cdf_done(cdf_done),
    .cdf_valid(cdf_valid),
    .cdf_min_in(cdf_min_in),
    .map_done(map_done),
    .hist_start(hist_start),
    .cdf_start(cdf_start),
    .map_start(map_start),
    .m2_owner(m2_owner),
    .input_base_offset(input_base_offset),
    .cdf_min(cdf_min),
    .busy(busy),
    .frame_done(frame_done),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  out_t act;
  assign act = {hist_start, cdf_start, map_start, m2_owner, busy, frame_done,
                err_timeout, input_base_offset, cdf_min};

  int   total = 0;
  int   bad   = 0;
  out_t exp_q[$];
  vec_t nom[$];

  function automatic in_t iv(logic g, logic b, logic hd, logic cd, logic cv,
                             logic [19:0] cm, logic md);
    in_t r;
    r.go = g; r.base = b; r.hd = hd; r.cd = cd; r.cv = cv; r.cm = cm; r.md = md;
    return r;
  endfunction

  // Expected output for a phase; starts/owner/busy are fixed per phase.
  function automatic out_t ph(int p, logic err, logic ibo, logic [19:0] cm);
    out_t r;
    r      = '0;
    r.err  = err;
    r.ibo  = ibo;
    r.cmin = cm;
    r.busy = (p != P_IDLE);
    r.fd   = (p == P_FIN);
    if (p == P_HIST) begin r.hs = 1'b1; r.own = 2'd1; end
    if (p == P_CDF)  begin r.cs = 1'b1; r.own = 2'd2; end
    if (p == P_MAP)  begin r.ms = 1'b1; r.own = 2'd3; end
    return r;
  endfunction

  function automatic vec_t mk(in_t i, int n, out_t e);
    vec_t v;
    v.i = i; v.n = n; v.e = e;
    return v;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("hs=%0b cs=%0b ms=%0b own=%0d busy=%0b fd=%0b err=%0b ibo=%0b cmin=%05h",
                     o.hs, o.cs, o.ms, o.own, o.busy, o.fd, o.err, o.ibo, o.cmin);
  endfunction

  task automatic check(string name, out_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got {%s} want {%s}", name, fmt(act), fmt(e));
    end
  endtask

  task automatic drive(in_t i);
    go         = i.go;
    frame_base = i.base;
    hist_done  = i.hd;
    cdf_done   = i.cd;
    cdf_valid  = i.cv;
    cdf_min_in = i.cm;
    map_done   = i.md;
  endtask

  // Hold a row's inputs for n edges; expectation is queued at drive time, popped after the edge.
  task automatic apply(string tag, vec_t v);
    for (int k = 0; k < v.n; k++) begin
      drive(v.i);
      exp_q.push_back(v.e);
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s[%0d] scoreboard empty", tag, k);
      end else begin
        check($sformatf("%s[%0d]", tag, k), exp_q.pop_front());
      end
    end
  endtask

  // Minimal complete frame: valid and done for CDF arrive in the same cycle.
  task automatic short_frame(string tag, logic base, logic ibo_run, logic ibo_fin);
    apply({tag, "_go"},   mk(iv(1, base, 0, 0, 0, 20'h0, 0), 1, ph(P_HIST, 0, ibo_run, 20'h0)));
    apply({tag, "_hd"},   mk(iv(0, 0, 1, 0, 0, 20'h0, 0), 1, ph(P_GAP, 0, ibo_run, 20'h0)));
    apply({tag, "_g1"},   mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 3, ph(P_GAP, 0, ibo_run, 20'h0)));
    apply({tag, "_cdf"},  mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1, ph(P_CDF, 0, ibo_run, 20'h0)));
    apply({tag, "_cd"},   mk(iv(0, 0, 0, 1, 1, 20'h0BEEF, 0), 1, ph(P_GAP, 0, ibo_run, 20'h0BEEF)));
    apply({tag, "_g2"},   mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 3, ph(P_GAP, 0, ibo_run, 20'h0BEEF)));
    apply({tag, "_map"},  mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1, ph(P_MAP, 0, ibo_run, 20'h0BEEF)));
    apply({tag, "_fin"},  mk(iv(0, 0, 0, 0, 0, 20'h0, 1), 1, ph(P_FIN, 0, ibo_fin, 20'h0BEEF)));
    apply({tag, "_idle"}, mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1, ph(P_IDLE, 0, ibo_fin, 20'h0BEEF)));
  endtask

  initial begin
    logic ibo_f;
    logic ibo2;
    logic ibo3;
    ibo_f = PP ? 1'b0 : 1'b1;
    ibo2  = PP ? 1'b0 : 1'b1;
    ibo3  = PP ? 1'b1 : 1'b0;

    // Nominal frame, base=1: HIST cycles 1-10, 4-cycle gaps, last cdf_valid wins, go in MAP ignored.
    nom.push_back(mk(iv(1, 1, 0, 0, 0, 20'h0, 0),     1,  ph(P_HIST, 0, 1, 20'h0)));
    nom.push_back(mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     9,  ph(P_HIST, 0, 1, 20'h0)));
    nom.push_back(mk(iv(0, 0, 1, 0, 0, 20'h0, 0),     1,  ph(P_GAP,  0, 1, 20'h0)));
    nom.push_back(mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     3,  ph(P_GAP,  0, 1, 20'h0)));
    nom.push_back(mk(iv(0, 0, 0, 0, 1, 20'hABCDE, 0), 1,  ph(P_CDF,  0, 1, 20'h0)));
    nom.push_back(mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     13, ph(P_CDF,  0, 1, 20'h0)));
    nom.push_back(mk(iv(0, 0, 0, 0, 1, 20'h00456, 0), 1,  ph(P_CDF,  0, 1, 20'h00456)));
    nom.push_back(mk(iv(0, 0, 0, 0, 1, 20'h00123, 0), 1,  ph(P_CDF,  0, 1, 20'h00123)));
    nom.push_back(mk(iv(0, 0, 0, 1, 0, 20'h0, 1),     1,  ph(P_GAP,  0, 1, 20'h00123)));
    nom.push_back(mk(iv(0, 0, 0, 1, 0, 20'h0, 0),     3,  ph(P_GAP,  0, 1, 20'h00123)));
    nom.push_back(mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     1,  ph(P_MAP,  0, 1, 20'h00123)));
    nom.push_back(mk(iv(1, 0, 0, 0, 0, 20'h0, 0),     15, ph(P_MAP,  0, 1, 20'h00123)));
    nom.push_back(mk(iv(1, 0, 0, 0, 0, 20'h0, 1),     1,  ph(P_FIN,  0, ibo_f, 20'h00123)));
    nom.push_back(mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     3,  ph(P_IDLE, 0, ibo_f, 20'h00123)));

    drive(iv(0, 0, 0, 0, 0, 20'h0, 0));
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("reset", '0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    apply("idle0", mk(iv(0, 0, 1, 1, 1, 20'h11111, 1), 2, ph(P_IDLE, 0, 0, 20'h0)));

    foreach (nom[r]) apply($sformatf("nom%0d", r), nom[r]);

    // Watchdog: CDF never completes; abort after the 100th CDF cycle.
    apply("to_go",    mk(iv(1, 0, 0, 0, 0, 20'h0, 0), 1,  ph(P_HIST, 0, 0, 20'h0)));
    apply("to_hd",    mk(iv(0, 0, 1, 0, 0, 20'h0, 0), 1,  ph(P_GAP,  0, 0, 20'h0)));
    apply("to_gap",   mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 3,  ph(P_GAP,  0, 0, 20'h0)));
    apply("to_cdf1",  mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1,  ph(P_CDF,  0, 0, 20'h0)));
    apply("to_cdf",   mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 99, ph(P_CDF,  0, 0, 20'h0)));
    apply("to_abort", mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1,  ph(P_IDLE, 1, 0, 20'h0)));
    apply("to_stky",  mk(iv(0, 0, 0, 1, 0, 20'h0, 1), 2,  ph(P_IDLE, 1, 0, 20'h0)));

    // Stale hist_done and map_done held through CDF, go in CDF, cdf_done with no cdf_valid.
    apply("st_go",   mk(iv(1, 1, 0, 0, 0, 20'h0, 0), 1, ph(P_HIST, 0, ibo2, 20'h0)));
    apply("st_h",    mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 2, ph(P_HIST, 0, ibo2, 20'h0)));
    apply("st_hd",   mk(iv(0, 0, 1, 0, 0, 20'h0, 0), 1, ph(P_GAP,  0, ibo2, 20'h0)));
    apply("st_g1",   mk(iv(0, 0, 1, 0, 0, 20'h0, 0), 3, ph(P_GAP,  0, ibo2, 20'h0)));
    apply("st_cdf",  mk(iv(0, 0, 1, 0, 0, 20'h0, 0), 1, ph(P_CDF,  0, ibo2, 20'h0)));
    apply("st_hold", mk(iv(1, 0, 1, 0, 0, 20'h0, 1), 5, ph(P_CDF,  0, ibo2, 20'h0)));
    apply("st_cd",   mk(iv(0, 0, 0, 1, 0, 20'h0, 0), 1, ph(P_GAP,  0, ibo2, 20'h0)));
    apply("st_g2",   mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 3, ph(P_GAP,  0, ibo2, 20'h0)));
    apply("st_map",  mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 3, ph(P_MAP,  0, ibo2, 20'h0)));
    apply("st_fin",  mk(iv(0, 0, 0, 0, 0, 20'h0, 1), 1, ph(P_FIN,  0, 1'b1, 20'h0)));
    apply("st_idle", mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1, ph(P_IDLE, 0, 1'b1, 20'h0)));

    // Async reset in the middle of CDF.
    apply("rs_go",  mk(iv(1, 0, 0, 0, 0, 20'h0, 0),     1, ph(P_HIST, 0, ibo3, 20'h0)));
    apply("rs_hd",  mk(iv(0, 0, 1, 0, 0, 20'h0, 0),     1, ph(P_GAP,  0, ibo3, 20'h0)));
    apply("rs_gap", mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     3, ph(P_GAP,  0, ibo3, 20'h0)));
    apply("rs_cdf", mk(iv(0, 0, 0, 0, 0, 20'h0, 0),     1, ph(P_CDF,  0, ibo3, 20'h0)));
    apply("rs_cv",  mk(iv(0, 0, 0, 0, 1, 20'h00777, 0), 1, ph(P_CDF,  0, ibo3, 20'h00777)));
    drive(iv(0, 0, 0, 0, 0, 20'h0, 0));
    #2 rst_n = 1'b0;
    #1 check("rst_async", '0);
    @(posedge clock);
    #1 check("rst_hold", '0);
    rst_n = 1'b1;
    apply("rs_idle", mk(iv(0, 0, 0, 0, 0, 20'h0, 0), 1, ph(P_IDLE, 0, 0, 20'h0)));

    // Two back-to-back clean frames with base=0 after reset.
    short_frame("fa", 1'b0, 1'b0, PP ? 1'b1 : 1'b0);
    short_frame("fb", 1'b0, PP ? 1'b1 : 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/heq_phase_sequencer.md
Name: heq_phase_sequencer

Overview:
Top-level phase controller for the histogram equalizer. Sequences one frame through three phases: histogram accumulation (input pipeline), CDF computation, and pixel remap/output. Drives each stage's level-sensitive start and grants ownership of scratchpad memory m2 to exactly one stage at a time. Inserts drain gaps between phases so in-flight pipeline writes retire before the next owner reads. Captures cdf_min for the remap stage and flags hung phases.

Parameters:
GAP_CYCLES, 4, idle cycles between phases to flush pipeline writes (1..15)
TIMEOUT_CYCLES, 24'd2000000, max cycles any single phase may run before abort
CNT_W, 24, width of the phase watchdog counter

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
go  in  1  frame request; sampled only in IDLE
frame_base  in  1  input memory bank select for the next frame
hist_done  in  1  histogram stage complete (level)
cdf_done  in  1  CDF stage complete (level)
cdf_valid  in  1  cdf_min_in is valid
cdf_min_in  in  20  minimum non-zero CDF value from CDF stage
map_done  in  1  remap stage complete (level)
hist_start  out  1  histogram stage run enable (held high for whole phase)
cdf_start  out  1  CDF stage run enable
map_start  out  1  remap stage run enable
m2_owner  out  2  scratchpad owner: 0 none, 1 hist, 2 cdf, 3 map
input_base_offset  out  1  bank select latched at frame start
cdf_min  out  20  latched CDF minimum for remap
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on successful frame completion
err_timeout  out  1  sticky; set on watchdog abort, cleared by next accepted go

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, HIST, GAP1, CDF, GAP2, MAP, FIN.
- IDLE: on go=1 -> HIST next cycle; latch frame_base into input_base_offset; clear err_timeout and cdf_min.
- HIST: hist_start=1, m2_owner=1. hist_done=1 -> GAP1; hist_start drops the cycle after hist_done is seen.
- GAP1/GAP2: all starts 0, m2_owner=0, for exactly GAP_CYCLES cycles, then CDF/MAP.
- CDF: cdf_start=1, m2_owner=2. Any cycle with cdf_valid=1 latches cdf_min_in (last value wins). cdf_done=1 -> GAP2. cdf_done without any prior cdf_valid in the phase: cdf_min stays 0, proceed anyway.
- MAP: map_start=1, m2_owner=3. map_done=1 -> FIN.
- FIN: frame_done=1 for one cycle -> IDLE.
- Starts and m2_owner are registered outputs, decoded from next-state; they change on the same edge as the state, so the first cycle in a phase already shows the start high.
- Done inputs are ignored outside their own phase (stale level from previous stage is harmless).
- go while busy: ignored, not queued.
- Watchdog: counter cleared on every state entry, increments in HIST/CDF/MAP; at TIMEOUT_CYCLES-1 without done -> set err_timeout, drop all starts, m2_owner=0, -> IDLE; no frame_done. Counter saturates, never wraps.
- Reset mid-frame: immediate return to IDLE with all outputs 0; stage starts drop asynchronously.
- input_base_offset constant for whole frame.

Optional Feature:
HEQ_PINGPONG_EN: when defined, frame_base is ignored after the first frame; input_base_offset toggles automatically on each frame_done so consecutive frames alternate banks (first frame uses frame_base). Toggle does not occur on timeout abort. When undefined, input_base_offset is always latched from frame_base at go.

Test Plan:
- Nominal: go=1, base=1; hist_done at cycle 10, cdf_valid with 0x00123 then cdf_done at 30, map_done at 50 -> hist_start cycles 1-10, 4-cycle gaps, cdf_min=0x00123, one frame_done pulse, input_base_offset=1 throughout.
- Ownership: sample m2_owner every cycle of nominal run -> sequence 1,0x4,2,0x4,3,0; never two starts high simultaneously.
- Timeout: TIMEOUT_CYCLES=100, never assert cdf_done -> err_timeout=1 at 100th CDF cycle, cdf_start=0, busy=0, no frame_done; next go clears err_timeout.
- go during MAP and stale hist_done=1 held through CDF -> no restart, no premature state change.
- rst_n low in CDF phase -> all outputs 0 immediately; next go runs a clean frame.
- HEQ_PINGPONG_EN defined, base=0, two back-to-back frames -> input_base_offset 0 then 1.
